// File: rtl/sd_rr_arbmux.sv
// Round-robin N:1 srdy/drdy arbiter-multiplexer with a registered output word.
// Define SDLIB_ARB_LOCK_EN to hold the grant on one requester until its end-of-packet.
module sd_rr_arbmux #(
    parameter int width  = 16,
    parameter int inputs = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [inputs-1:0]       c_srdy,
    output logic [inputs-1:0]       c_drdy,
    input  logic [inputs*width-1:0] c_data,
    input  logic [inputs-1:0]       c_eop,
    output logic                    p_srdy,
    input  logic                    p_drdy,
    output logic [width-1:0]        p_data,
    output logic                    p_eop,
    output logic [inputs-1:0]       p_grant
);

    localparam int ptr_w = (inputs > 1) ? $clog2(inputs) : 1;
    localparam logic [ptr_w:0]   NUM  = (ptr_w+1)'(inputs);
    localparam logic [ptr_w-1:0] LAST = ptr_w'(inputs - 1);

    logic [ptr_w-1:0]  ptr_q, ptr_d;
    logic              p_srdy_q, p_srdy_d;
    logic [width-1:0]  p_data_q, p_data_d;
    logic              p_eop_q, p_eop_d;
    logic [inputs-1:0] p_grant_q, p_grant_d;

    logic [inputs-1:0] req;
    logic              win_vld;
    logic [ptr_w-1:0]  win_idx;
    logic [ptr_w-1:0]  win_nxt;
    logic [ptr_w:0]    cand;
    logic              ld;

`ifdef SDLIB_ARB_LOCK_EN
    logic             lock_q, lock_d;
    logic [ptr_w-1:0] lockid_q, lockid_d;

    // A locked packet owner hides every other requester, even while it idles.
    always_comb begin
        req = '0;
        if (lock_q) begin
            req[lockid_q] = c_srdy[lockid_q];
        end else begin
            req = c_srdy;
        end
    end
`else
    assign req = c_srdy;
`endif

    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int off = 0; off < inputs; off++) begin
            cand = {1'b0, ptr_q} + (ptr_w+1)'(off);
            if (cand >= NUM) begin
                cand = cand - NUM;
            end
            if (!win_vld && req[cand[ptr_w-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[ptr_w-1:0];
            end
        end
    end

    assign win_nxt = (win_idx == LAST) ? '0 : win_idx + 1'b1;

    // Load when the output slot is empty or being drained this cycle.
    assign ld = win_vld && (!p_srdy_q || p_drdy) && reset;

    always_comb begin
        c_drdy          = '0;
        c_drdy[win_idx] = ld;
    end

    always_comb begin
        ptr_d     = ptr_q;
        p_srdy_d  = p_srdy_q;
        p_data_d  = p_data_q;
        p_eop_d   = p_eop_q;
        p_grant_d = p_grant_q;
`ifdef SDLIB_ARB_LOCK_EN
        lock_d    = lock_q;
        lockid_d  = lockid_q;
`endif
        if (ld) begin
            p_srdy_d           = 1'b1;
            p_data_d           = c_data[int'(win_idx)*width +: width];
            p_eop_d            = c_eop[win_idx];
            p_grant_d          = '0;
            p_grant_d[win_idx] = 1'b1;
`ifdef SDLIB_ARB_LOCK_EN
            if (c_eop[win_idx]) begin
                lock_d = 1'b0;
                ptr_d  = win_nxt;
            end else begin
                lock_d   = 1'b1;
                lockid_d = win_idx;
            end
`else
            ptr_d = win_nxt;
`endif
        end else if (p_srdy_q && p_drdy) begin
            p_srdy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q     <= '0;
            p_srdy_q  <= 1'b0;
            p_data_q  <= '0;
            p_eop_q   <= 1'b0;
            p_grant_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            p_srdy_q  <= p_srdy_d;
            p_data_q  <= p_data_d;
            p_eop_q   <= p_eop_d;
            p_grant_q <= p_grant_d;
        end
    end

`ifdef SDLIB_ARB_LOCK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_q   <= 1'b0;
            lockid_q <= '0;
        end else begin
            lock_q   <= lock_d;
            lockid_q <= lockid_d;
        end
    end
`endif

    assign p_srdy  = p_srdy_q;
    assign p_data  = p_data_q;
    assign p_eop   = p_eop_q;
    assign p_grant = p_grant_q;

endmodule

// File: tb/tb_sd_rr_arbmux.sv
// Directed and random stimulus for sd_rr_arbmux against a cycle-level
// reference model of the round-robin / packet-lock rules.
module tb_sd_rr_arbmux;

    localparam int W = 16;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   c_srdy;
    logic [N-1:0]   c_drdy;
    logic [N*W-1:0] c_data;
    logic [N-1:0]   c_eop;
    logic           p_srdy;
    logic           p_drdy;
    logic [W-1:0]   p_data;
    logic           p_eop;
    logic [N-1:0]   p_grant;

    sd_rr_arbmux #(.width(W), .inputs(N)) dut (
        .clk(clk), .reset(reset),
        .c_srdy(c_srdy), .c_drdy(c_drdy), .c_data(c_data), .c_eop(c_eop),
        .p_srdy(p_srdy), .p_drdy(p_drdy), .p_data(p_data), .p_eop(p_eop),
        .p_grant(p_grant)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    int           m_ptr;
    bit           m_lock;
    int           m_lockid;
    bit           m_srdy;
    logic [W-1:0] m_data;
    bit           m_eop;
    logic [N-1:0] m_grant;

    int cnt[N];
    bit eop_cur[N];
    int eop_mode[N];
    int gseq[$];

`ifdef SDLIB_ARB_LOCK_EN
    int exp_lk[5] = '{1, 1, 1, 0, 1};
`else
    int exp_lk[5] = '{1, 0, 1, 0, 1};
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] word_of(input int i);
        return {4'(i), 12'(cnt[i])};
    endfunction

    function automatic bit next_eop(input int i);
        case (eop_mode[i])
            0:       return bit'($urandom_range(0, 1));
            1:       return (cnt[i] % 3) == 2;
            default: return 1'b1;
        endcase
    endfunction

    function automatic int model_win();
        for (int off = 0; off < N; off++) begin
            int i;
            i = (m_ptr + off) % N;
            if (c_srdy[i] && (!m_lock || i == m_lockid)) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_lock = 0; m_lockid = 0; m_srdy = 0;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            c_data[i*W +: W] = word_of(i);
            c_eop[i]         = eop_cur[i];
        end
    endtask

    // One clock: check c_drdy mid-cycle, advance model at the edge, check outputs.
    task automatic step();
        int w;
        bit ld;
        logic [N-1:0] exp_drdy;
        drive();
        #2;
        w  = model_win();
        ld = (w >= 0) && (!m_srdy || p_drdy);
        exp_drdy = '0;
        if (ld) exp_drdy[w] = 1'b1;
        chk("c_drdy", 32'(c_drdy), 32'(exp_drdy));
        @(posedge clk);
        #1;
        if (ld) begin
            m_srdy  = 1;
            m_data  = word_of(w);
            m_eop   = eop_cur[w];
            m_grant = N'(1) << w;
            gseq.push_back(w);
`ifdef SDLIB_ARB_LOCK_EN
            if (!eop_cur[w]) begin
                m_lock = 1; m_lockid = w;
            end else begin
                m_lock = 0; m_ptr = (w + 1) % N;
            end
`else
            m_ptr = (w + 1) % N;
`endif
            cnt[w]++;
            eop_cur[w] = next_eop(w);
        end else if (p_drdy) begin
            m_srdy = 0;
        end
        chk("p_srdy", 32'(p_srdy), 32'(m_srdy));
        if (m_srdy) begin
            chk("p_data", 32'(p_data), 32'(m_data));
            chk("p_eop", 32'(p_eop), 32'(m_eop));
            chk("p_grant", 32'(p_grant), 32'(m_grant));
        end
    endtask

    initial begin
        reset  = 1'b0;
        c_srdy = '0;
        c_data = '0;
        c_eop  = '0;
        p_drdy = 1'b1;
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0; eop_cur[i] = 1'b1; eop_mode[i] = 2;
        end
        model_reset();

        // reset state, c_drdy gated while reset is held
        #12;
        c_srdy = 4'b1111;
        #1;
        chk("rst_p_srdy", 32'(p_srdy), 32'd0);
        chk("rst_p_data", 32'(p_data), 32'd0);
        chk("rst_p_eop", 32'(p_eop), 32'd0);
        chk("rst_p_grant", 32'(p_grant), 32'd0);
        chk("rst_c_drdy", 32'(c_drdy), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // all requesting: rotate 0,1,2,3,...
        gseq.delete();
        repeat (8) step();
        for (int i = 0; i < 8; i++) chk("rot_seq", 32'(gseq[i]), 32'(i % 4));

        // single requester 2, back to back
        c_srdy = 4'b0100;
        gseq.delete();
        repeat (5) step();
        for (int i = 0; i < 5; i++) chk("single_seq", 32'(gseq[i]), 32'd2);
        c_srdy = '0;
        step();

        // pointer at 3 with 1001: 3 then wrap to 0
        c_srdy = 4'b1001;
        gseq.delete();
        repeat (2) step();
        chk("wrap_first", 32'(gseq[0]), 32'd3);
        chk("wrap_second", 32'(gseq[1]), 32'd0);

        // stall: output held, no c_drdy; then drain+load same cycle
        c_srdy = 4'b0011;
        p_drdy = 1'b0;
        repeat (3) step();
        p_drdy = 1'b1;
        step();
        step();

        // async reset while p_srdy=1
        c_srdy = 4'b1111;
        p_drdy = 1'b0;
        step();
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        chk("arst_p_srdy", 32'(p_srdy), 32'd0);
        chk("arst_c_drdy", 32'(c_drdy), 32'd0);
        @(posedge clk);
        #1;
        reset  = 1'b1;
        p_drdy = 1'b1;
        c_srdy = 4'b0110;
        gseq.delete();
        step();
        chk("arst_first", 32'(gseq[0]), 32'd1);
        c_srdy = '0;
        step();

        // packet from requester 1 against requester 0
        c_srdy = 4'b0001;
        step();
        cnt[1] = 0; eop_mode[1] = 1; eop_cur[1] = 1'b0;
        c_srdy = 4'b0011;
        gseq.delete();
        repeat (5) step();
        for (int i = 0; i < 5; i++) chk("pkt_seq", 32'(gseq[i]), 32'(exp_lk[i]));

        // random traffic
        for (int i = 0; i < N; i++) eop_mode[i] = 0;
        for (int k = 0; k < 400; k++) begin
            c_srdy = N'($urandom);
            p_drdy = ($urandom_range(0, 3) != 0);
            step();
        end
        c_srdy = '0;
        p_drdy = 1'b1;
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
